// File: rtl/risc_instr_encoder_if.sv
// Record-in / word-out stream bundle for the instruction encoder.
// master = program source + memory side, slave = encoder.
interface risc_instr_encoder_if #(
  parameter int INSTR_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                in_kind;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic [REG_ADDR_WIDTH-1:0] in_rs1;
  logic [REG_ADDR_WIDTH-1:0] in_rs2;
  logic [12:0]               in_imm;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [INSTR_WIDTH-1:0]    out_data;
  logic [ADDR_WIDTH-1:0]     out_addr;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1,
    output in_rs2, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1,
    input  in_rs2, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/risc_instr_encoder.sv
// Streaming assembler back-end: symbolic records -> 32-bit words + addresses.
// Optional ENC_CHECKSUM_EN adds out_checksum (XOR of popped words).
module risc_instr_encoder #(
  parameter int                    INSTR_WIDTH    = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    REG_ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  risc_instr_encoder_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_range,
  output logic [15:0]           word_count
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [INSTR_WIDTH-1:0] out_checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [INSTR_WIDTH-1:0] word;
  } entry_t;

  state_t state, state_nx;
  logic   done_nx;
  logic   start_go;

  logic [ADDR_WIDTH-1:0] addr;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       full;
  logic       empty;

  logic accept;
  logic push;
  logic pop;

  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [12:0]               imm;

  logic k_r, k_addi, k_lw, k_sw, k_beq;
  logic legal;
  logic range_ok;
  logic [INSTR_WIDTH-1:0] enc;

  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  assign bus.in_ready  = (state == RUN) && !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr].word;
  assign bus.out_addr  = mem[rd_ptr].addr;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal && range_ok;
  assign pop    = bus.out_valid && bus.out_ready;
  assign busy   = (state != IDLE);

  assign k_r    = (bus.in_kind == 3'd0) || (bus.in_kind == 3'd1);
  assign k_addi = (bus.in_kind == 3'd2);
  assign k_lw   = (bus.in_kind == 3'd3);
  assign k_sw   = (bus.in_kind == 3'd4);
  assign k_beq  = (bus.in_kind == 3'd5);

  // Encode the presented record and judge its immediate.
  always_comb begin
    enc      = '0;
    legal    = 1'b1;
    range_ok = 1'b1;
    unique case (1'b1)
      k_r: begin
        enc = {1'b0, bus.in_kind[0], 5'b0, rs2, rs1,
               3'b000, rd, 7'b0110011};
      end
      k_addi: begin
        range_ok = (imm[12] == imm[11]);
        enc = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      end
      k_lw: begin
        range_ok = (imm[12] == imm[11]);
        enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      end
      k_sw: begin
        range_ok = (imm[12] == imm[11]);
        enc = {imm[11:5], rs2, rs1, 3'b010,
               imm[4:0], 7'b0100011};
      end
      k_beq: begin
        range_ok = !imm[0];
        enc = {imm[12], imm[10:5], rs2, rs1, 3'b000,
               imm[4:1], imm[11], 7'b1100011};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Load-sequence FSM: next state, start strobe, done request.
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    start_go = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          start_go = 1'b1;
        end
      end
      RUN: begin
        if (accept && bus.in_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (empty) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  // Address, word count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= BASE_ADDR;
      word_count  <= '0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else if (start_go) begin
      addr        <= BASE_ADDR;
      word_count  <= '0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (accept && !legal) err_illegal <= 1'b1;
      if (accept && legal && !range_ok) err_range <= 1'b1;
      if (push) begin
        addr <= addr + ADDR_WIDTH'(4);
        if (word_count != 16'hFFFF)
          word_count <= word_count + 16'd1;
      end
    end
  end

  // Two-entry output FIFO of {address, word}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{addr: addr, word: enc};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef ENC_CHECKSUM_EN
  // Running XOR of every word handed to memory since start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_checksum <= '0;
    end else if (start_go) begin
      out_checksum <= '0;
    end else if (pop) begin
      out_checksum <= out_checksum ^ bus.out_data;
    end
  end
`endif

endmodule
